// File: rtl/rotation_scheduler.sv
// -----------------------------------------------------------------------------
// rotation_scheduler
//
// Sequencer for the rotating 4-digit HEX display. Owns the step prescaler and
// the rotation offset that drives the digit-select muxes. A start command runs
// REVS full revolutions at a period of TICK_DIV >> speed clocks per position.
// The run can be held, aborted or restarted. While idle, single manual steps
// are accepted.
//
// Ports:
//   clk    in   system clock
//   sclr   in   synchronous active-high reset, overrides everything
//   start  in   pulse: begin or restart a run (latches speed)
//   stop   in   pulse: abort the run
//   hold   in   level: freeze the run while high
//   step   in   pulse: manual single advance, idle only
//   dir    in   1 = increment pos, 0 = decrement pos (live)
//   speed  in   period select, step period = TICK_DIV >> speed
//   pos    out  rotation offset 0..N_POS-1 (mux select)
//   tick   out  pulse in the first cycle a new pos is visible
//   busy   out  high while a run is active (RUN or HOLD)
//   done   out  pulse together with the final tick of a completed run
// -----------------------------------------------------------------------------
module rotation_scheduler #(
   parameter  int unsigned TICK_DIV = 50000000,
   parameter  int unsigned N_POS    = 4,
   parameter  int unsigned REVS     = 3,
   localparam int unsigned PW       = (N_POS > 1) ? $clog2(N_POS) : 1
) (
   input  logic          clk,
   input  logic          sclr,
   input  logic          start,
   input  logic          stop,
   input  logic          hold,
   input  logic          step,
   input  logic          dir,
   input  logic [1:0]    speed,
   output logic [PW-1:0] pos,
   output logic          tick,
   output logic          busy,
   output logic          done
);

   // Bits needed to hold TICK_DIV-1 and REVS*N_POS respectively.
   localparam int unsigned CW = $clog2(TICK_DIV);
   localparam int unsigned SW = $clog2(REVS * N_POS + 1);

   localparam logic [SW-1:0] STEPS_PER_RUN = SW'(REVS * N_POS);
   localparam logic [PW-1:0] POS_MAX       = PW'(N_POS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [CW-1:0] presc_q, presc_d;
   // The period is stored as div-1 so it fits the prescaler width.
   logic [CW-1:0] div_m1_q, div_m1_d;
   logic [SW-1:0] steps_q, steps_d;
   logic          tick_q, tick_d;
   logic          done_q, done_d;

   logic [31:0]   div_full;
   logic          at_wrap;
   logic          last_adv;

   function automatic logic [PW-1:0] next_pos(input logic [PW-1:0] p, input logic up);
      if (up) begin
         return (p == POS_MAX) ? '0 : p + PW'(1);
      end
      return (p == '0) ? POS_MAX : p - PW'(1);
   endfunction

   assign busy     = (state_q != S_IDLE);
   assign at_wrap  = (presc_q == div_m1_q);
   // Final advance of a run: only when nothing of higher priority intervenes.
   assign last_adv = busy && !stop && !start && !hold && at_wrap && (steps_q == SW'(1));

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Priority: stop > start > hold > counting.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !stop) state_d = S_RUN;
         end
         S_RUN, S_HOLD: begin
            if (stop)          state_d = S_IDLE;
            else if (start)    state_d = hold ? S_HOLD : S_RUN;
            else if (hold)     state_d = S_HOLD;
            else if (last_adv) state_d = S_IDLE;
            else               state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath / output next-state logic. HOLD with hold low counts exactly
   // like RUN, so the prescaler is frozen for precisely the cycles hold is high.
   // NOTE: every signal gets a default before any branch, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      pos_d    = pos_q;
      presc_d  = presc_q;
      div_m1_d = div_m1_q;
      steps_d  = steps_q;
      tick_d   = 1'b0;
      done_d   = 1'b0;
      div_full = TICK_DIV >> speed;

      if (stop) begin
         presc_d = '0;
      end else if (start) begin
         div_m1_d = CW'(div_full - 32'd1);
         steps_d  = STEPS_PER_RUN;
         presc_d  = '0;
      end else if (busy) begin
         if (!hold) begin
            if (at_wrap) begin
               presc_d = '0;
               pos_d   = next_pos(pos_q, dir);
               steps_d = steps_q - SW'(1);
               tick_d  = 1'b1;
               done_d  = (steps_q == SW'(1));
            end else begin
               presc_d = presc_q + CW'(1);
            end
         end
      end else if (step) begin
         pos_d  = next_pos(pos_q, dir);
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         pos_q    <= '0;
         presc_q  <= '0;
         div_m1_q <= CW'(TICK_DIV - 1);
         steps_q  <= '0;
         tick_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         pos_q    <= pos_d;
         presc_q  <= presc_d;
         div_m1_q <= div_m1_d;
         steps_q  <= steps_d;
         tick_q   <= tick_d;
         done_q   <= done_d;
      end
   end

   assign pos  = pos_q;
   assign tick = tick_q;
   assign done = done_q;

endmodule
